// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and width default.
// Ports: none (package).
// Imported by the divider top level.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between an ALU client and the sequential divider.
// Ports: start/dividend/divisor (client -> divider); busy/done/quotient/remainder/div_by_zero (divider -> client).
// master = client side, slave = divider side.
interface seq_divider_if #(parameter int WIDTH = 32);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_nbit_subtractor.sv
// Combinational subtractor: out = i1 - i2, borrow set when i2 > i1.
// Ports: i1, i2 (operands), out (difference), borrow (borrow-out).
// Built as i1 + ~i2 + 1; a missing carry-out means a borrow occurred.
module nbit_subtractor #(
  parameter int WIDTH = 33
) (
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2
);

  logic [WIDTH:0] sum;

  assign sum    = {1'b0, i1} + {1'b0, ~i2} + {{WIDTH{1'b0}}, 1'b1};
  assign out    = sum[WIDTH-1:0];
  assign borrow = ~sum[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Restoring shift-and-subtract unsigned divider, one quotient bit per clock.
// Ports: clk, rst_n (async active-low), bus (slave side of seq_divider_if).
// Latency WIDTH cycles from capture to done (1 for a zero divisor); start is ignored while busy.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  // The partial remainder always stays below the divisor, so its bit WIDTH
  // is zero after every restore step and only the low WIDTH bits are kept.
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvsr;
  logic             dz;

  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dz_r;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] p_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             unused_trial_msb;

  assign shifted = {p, q[WIDTH-1]};

  nbit_subtractor #(.WIDTH(WIDTH + 1)) u_sub (
    .out    (trial),
    .borrow (borrow),
    .i1     (shifted),
    .i2     ({1'b0, dvsr})
  );

  // On no-borrow the trial is below the divisor, so its MSB is always zero.
  assign unused_trial_msb = trial[WIDTH];

  assign p_nxt = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_nxt = {q[WIDTH-2:0], ~borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      p           <= '0;
      q           <= '0;
      dvsr        <= '0;
      dz          <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dz_r        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            dvsr   <= bus.divisor;
            p      <= '0;
            q      <= bus.dividend;
            busy_r <= 1'b1;
            state  <= ST_RUN;
            // A zero divisor spends one cycle in RUN without iterating so
            // that done still lands one edge after capture.
            if (bus.divisor == '0) begin
              dz  <= 1'b1;
              cnt <= '0;
            end else begin
              dz  <= 1'b0;
              cnt <= CW'(WIDTH - 1);
            end
          end
        end

        ST_RUN: begin
          if (dz) begin
            quotient_r  <= '1;
            remainder_r <= q;  // Q still holds the untouched dividend
            dz_r        <= 1'b1;
            done_r      <= 1'b1;
            state       <= ST_DONE;
          end else begin
            p <= p_nxt;
            q <= q_nxt;
            if (cnt == '0) begin
              quotient_r  <= q_nxt;
              remainder_r <= p_nxt;
              dz_r        <= 1'b0;
              done_r      <= 1'b1;
              state       <= ST_DONE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end

        ST_DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dz_r;

endmodule
